// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//
// Purpose:
//   Drives an NB_LEDS-wide LED pattern that advances once per prescaler tick.
//   The prescaler period is chosen at run time from four build-time limits.
//   There are four patterns: rotate left, rotate right, ping-pong and blink.
//   i_enable pauses both the prescaler and the pattern.
//
// Ports:
//   clock     in   1        system clock, every flop uses the rising edge
//   i_reset   in   1        synchronous, active-high reset
//   i_enable  in   1        1 = prescaler runs, 0 = counter and pattern hold
//   i_rate    in   2        selects LIMIT_R0..LIMIT_R3 as the tick period
//   i_mode    in   2        00 rot-left, 01 rot-right, 10 ping-pong, 11 blink
//   o_led     out  NB_LEDS  current pattern (registered)
//   o_valid   out  1        one-cycle pulse in the cycle o_led has just updated
//   o_dir     out  1        ping-pong direction (0 toward MSB, 1 toward LSB)
//
// Every output comes straight from a flop. No combinational path runs from
// the inputs to the outputs.
// -----------------------------------------------------------------------------
module led_pattern_gen #(
    parameter int NB_LEDS  = 4,
    parameter int NB_COUNT = 32,
    parameter int LIMIT_R0 = 50000000,
    parameter int LIMIT_R1 = 25000000,
    parameter int LIMIT_R2 = 12500000,
    parameter int LIMIT_R3 = 6250000
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [1:0]         i_rate,
    input  logic [1:0]         i_mode,
    output logic [NB_LEDS-1:0] o_led,
    output logic               o_valid,
    output logic               o_dir
);

    typedef enum logic [1:0] {
        MODE_ROT_L = 2'b00,
        MODE_ROT_R = 2'b01,
        MODE_PING  = 2'b10,
        MODE_BLINK = 2'b11
    } mode_e;

    // Tick periods, truncated to the counter width once.
    localparam logic [NB_COUNT-1:0] LIM_0 = NB_COUNT'(LIMIT_R0);
    localparam logic [NB_COUNT-1:0] LIM_1 = NB_COUNT'(LIMIT_R1);
    localparam logic [NB_COUNT-1:0] LIM_2 = NB_COUNT'(LIMIT_R2);
    localparam logic [NB_COUNT-1:0] LIM_3 = NB_COUNT'(LIMIT_R3);

    localparam logic [NB_LEDS-1:0] PAT_LSB  = {{(NB_LEDS-1){1'b0}}, 1'b1};
    localparam logic [NB_LEDS-1:0] PAT_MSB  = {1'b1, {(NB_LEDS-1){1'b0}}};
    localparam logic [NB_LEDS-1:0] PAT_ONES = {NB_LEDS{1'b1}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NB_COUNT-1:0] cnt_q,   cnt_d;
    logic [NB_LEDS-1:0]  led_q,   led_d;
    logic                dir_q,   dir_d;
    logic                valid_q;
    mode_e               mode_q,  mode_d;

    logic [NB_COUNT-1:0] lim_s;
    logic [NB_COUNT-1:0] lim_m1_s;
    logic                tick_s;
    mode_e               mode_in_s;

    assign mode_in_s = mode_e'(i_mode);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Pattern loaded when the requested mode differs from the active one.
    function automatic logic [NB_LEDS-1:0] init_pattern(input mode_e m);
        logic [NB_LEDS-1:0] p;
        case (m)
            MODE_ROT_L: p = PAT_LSB;
            MODE_ROT_R: p = PAT_MSB;
            MODE_PING:  p = PAT_LSB;
            MODE_BLINK: p = PAT_ONES;
            default:    p = PAT_LSB;
        endcase
        return p;
    endfunction

    // The MSB wraps around to bit 0.
    function automatic logic [NB_LEDS-1:0] rot_left(input logic [NB_LEDS-1:0] p);
        return {p[NB_LEDS-2:0], p[NB_LEDS-1]};
    endfunction

    // Bit 0 wraps around to the MSB.
    function automatic logic [NB_LEDS-1:0] rot_right(input logic [NB_LEDS-1:0] p);
        return {p[0], p[NB_LEDS-1:1]};
    endfunction

    // -------------------------------------------------------------------------
    // Prescaler
    // -------------------------------------------------------------------------

    // Rate mux. It feeds the comparison directly, so a rate change takes effect
    // in the same cycle.
    always_comb begin
        lim_s = LIM_0;
        case (i_rate)
            2'd0:    lim_s = LIM_0;
            2'd1:    lim_s = LIM_1;
            2'd2:    lim_s = LIM_2;
            2'd3:    lim_s = LIM_3;
            default: lim_s = LIM_0;
        endcase
        // Every limit is at least 1, so this never underflows.
        lim_m1_s = lim_s - {{(NB_COUNT-1){1'b0}}, 1'b1};
    end

    // Terminal-count detection. The test is >= rather than ==, so that when
    // the period shrinks below the current count the counter ticks on the
    // next enabled cycle instead of wrapping through 2^NB_COUNT.
    always_comb begin
        cnt_d  = cnt_q;
        tick_s = 1'b0;
        if (i_enable) begin
            if (cnt_q >= lim_m1_s) begin
                cnt_d  = {NB_COUNT{1'b0}};
                tick_s = 1'b1;
            end else begin
                cnt_d  = cnt_q + {{(NB_COUNT-1){1'b0}}, 1'b1};
                tick_s = 1'b0;
            end
        end else begin
            cnt_d  = cnt_q;
            tick_s = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Pattern next-state
    // -------------------------------------------------------------------------

    // The pattern changes only on a tick. A pending mode change wins over
    // advancing the current pattern, and the load counts as the update.
    always_comb begin
        led_d  = led_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        if (tick_s) begin
            if (mode_in_s != mode_q) begin
                mode_d = mode_in_s;
                led_d  = init_pattern(mode_in_s);
                dir_d  = 1'b0;
            end else begin
                case (mode_q)
                    MODE_ROT_L: begin
                        led_d = rot_left(led_q);
                        dir_d = 1'b0;
                    end
                    MODE_ROT_R: begin
                        led_d = rot_right(led_q);
                        dir_d = 1'b0;
                    end
                    MODE_PING: begin
                        // Reverse at the end bit and move off it on the same
                        // tick, so the pattern never dwells at either end.
                        if (dir_q == 1'b0) begin
                            if (led_q[NB_LEDS-1]) begin
                                dir_d = 1'b1;
                                led_d = led_q >> 1;
                            end else begin
                                dir_d = 1'b0;
                                led_d = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                dir_d = 1'b0;
                                led_d = led_q << 1;
                            end else begin
                                dir_d = 1'b1;
                                led_d = led_q >> 1;
                            end
                        end
                    end
                    MODE_BLINK: begin
                        led_d = ~led_q;
                        dir_d = 1'b0;
                    end
                    default: begin
                        led_d = init_pattern(mode_in_s);
                        dir_d = 1'b0;
                    end
                endcase
            end
        end else begin
            led_d  = led_q;
            dir_d  = dir_q;
            mode_d = mode_q;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------

    // All state updates here. Reset overrides every other input and discards
    // any partial count.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            cnt_q   <= {NB_COUNT{1'b0}};
            led_q   <= PAT_LSB;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            mode_q  <= MODE_ROT_L;
        end else begin
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            valid_q <= tick_s;
            mode_q  <= mode_d;
        end
    end

    assign o_led   = led_q;
    assign o_valid = valid_q;
    assign o_dir   = dir_q;

endmodule
